// File: rtl/wb_master_cmd.sv
// wb_master_cmd: one-shot command to single Wishbone B4 pipelined transaction with bounded retry; optional timeout under WBM_TIMEOUT_EN
module wb_master_cmd #(
   parameter int ADDR_W         = 32,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_req_i,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_adr_i,
   input  logic [31:0]       cmd_dat_i,
   input  logic [3:0]        cmd_sel_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        status_o,
   output logic [31:0]       rdata_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [3:0]        wb_sel_o,
   output logic [31:0]       wb_dat_o,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   input  logic              wb_rty_i,
   input  logic              wb_stall_i,
   input  logic [31:0]       wb_dat_i
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, DONE} state_t;
   localparam logic [3:0] MAX_R = 4'(MAX_RETRY);
   state_t state;
   logic [3:0] rty_cnt;
   logic act, take, resp, retry, fin, tmo_hit;
   logic [1:0] fin_st;
   // response decode: err > rty > ack, timeout only when nothing answered
   always_comb begin
      act    = state == REQ || state == WAIT;
      take   = state == WAIT || (state == REQ && !wb_stall_i);
      resp   = take && (wb_err_i || wb_rty_i || wb_ack_i);
      retry  = take && !wb_err_i && wb_rty_i && rty_cnt != MAX_R;
      fin    = act && !retry && (resp || tmo_hit);
      fin_st = !resp ? 2'b11 : wb_err_i ? 2'b01 : wb_rty_i ? 2'b10 : 2'b00;
   end
`ifdef WBM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_cnt;
   // cycles of cyc=1 since the latest REQ entry
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) tmo_cnt <= '0;
      else if (!act) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
   assign tmo_hit = act && tmo_cnt == TMO_LAST;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif
   // transaction FSM with registered bus and handshake outputs
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state    <= IDLE;
         rty_cnt  <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         status_o <= 2'b00;
         rdata_o  <= '0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_sel_o <= '0;
         wb_dat_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (cmd_req_i) begin
               wb_we_o  <= cmd_we_i;
               wb_adr_o <= cmd_adr_i;
               wb_dat_o <= cmd_dat_i;
               wb_sel_o <= cmd_sel_i;
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               busy_o   <= 1'b1;
               state    <= REQ;
            end
            REQ, WAIT: if (fin) begin
               if (resp && !wb_err_i && !wb_rty_i && !wb_we_o) rdata_o <= wb_dat_i;
               status_o <= fin_st;
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               busy_o   <= 1'b0;
               done_o   <= 1'b1;
               rty_cnt  <= '0;
               state    <= DONE;
            end else if (retry) begin
               rty_cnt  <= rty_cnt + 4'd1;
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               state    <= GAP;
            end else if (state == REQ && !wb_stall_i) begin
               wb_stb_o <= 1'b0;
               state    <= WAIT;
            end
            GAP: begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               state    <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
